fifo_read_stream: RTL and testbench
===================================

// Module: fifo_read_stream
// PURPOSE
//  Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain.
//  Pops words from the FIFO read port (rdata / rinc / rempty) whenever the FIFO is non-empty
//  and there is local space, and presents them on a valid/ready streaming output.
//  A small FSM starts and stops fetching, and supports a clean drain on disable.
//  It also keeps a delivered-word counter.
// PARAMETERS
//  DSIZE  8   data word width; equals the FIFO DSIZE
//  CNTW   16  width of the delivered-word counter
// PORTS
//  rclk         in   1      read-domain clock; all logic is on the rising edge
//  rrst         in   1      synchronous, active-high reset
//  enable       in   1      1 = fetch from FIFO; 1->0 starts a drain
//  fifo_rdata   in   DSIZE  FIFO head word; valid whenever fifo_rempty=0 (first-word fall-through)
//  fifo_rempty  in   1      FIFO empty flag
//  fifo_rinc    out  1      FIFO pop strobe; the FIFO read pointer advances at the next rclk edge
//  m_data       out  DSIZE  output stream data
//  m_valid      out  1      output stream valid
//  m_ready      in   1      output stream ready from the sink
//  drain_done   out  1      one-cycle pulse: drain complete, buffer empty
//  busy         out  1      1 when state != IDLE
//  word_cnt     out  CNTW   count of words accepted by the sink (m_valid & m_ready)
// BEHAVIOUR
//  Reset (rrst=1 at an edge):
//   - state=IDLE, buffer count=0, m_valid=0, m_data=0, drain_done=0, word_cnt=0.
//   - fifo_rinc is forced to 0 combinationally while rrst=1.
//   - Buffered words are discarded. The FIFO pointers are untouched, because they are owned
//     by the FIFO's reset.
//  FSM (rd_state_e):
//   - IDLE:  no fetch. enable=1 -> RUN.
//   - RUN:   fetch permitted. enable=0 -> DRAIN.
//   - DRAIN: no fetch. When registered count==0 -> IDLE, and drain_done=1 for exactly one cycle.
//     enable is ignored until the drain completes; if enable=1 in IDLE, the next edge goes to RUN.
//  Fetch rule (combinational from registers and FIFO flags only):
//   - fifo_rinc = (state==RUN) & ~fifo_rempty & (count<2) & ~rrst.
//   - No combinational path from m_ready to fifo_rinc.
//   - fifo_rinc is never 1 while fifo_rempty=1.
//  Output buffer: 2 entries, entry0 = head.
//   - m_valid = (count!=0); m_data = entry0.
//   - push = fifo_rinc (captures fifo_rdata at the edge); pop = m_valid & m_ready.
//   - Push only: count+1; the word goes to the first free entry.
//   - Pop only: count-1; entry0<=entry1 when count==2.
//   - Push and pop at count=1: entry0<=new word, count stays 1.
//   - Push is not allowed at count=2 (fetch rule), so no overflow is possible.
//  Stream rule: while m_valid=1 and m_ready=0, m_data and m_valid hold stable.
//  Latency: count=0, non-empty FIFO, RUN -> fifo_rinc=1 in cycle N, m_valid=1 in cycle N+1.
//  Throughput: 1 word/cycle sustained with m_ready=1 (count settles at 1).
//  word_cnt: +1 on each pop, wraps modulo 2^CNTW, no saturation.
//  fifo_rempty rising while fifo_rinc=1 is never a hazard: the flag is sampled in the same
//   cycle that gates rinc.
// STRUCTURE
//  Shared package fifo_rd_pkg:
//   - typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_e
//   - localparam int RD_BUF_DEPTH = 2
//  Sub-module rd_skid_buffer (2-entry push/pop buffer, DSIZE param, count output).
//   The FSM, fetch gating and word counter stay in the top level.
// TESTING
//  1. Reset, then enable=1, FIFO holding 0xA5, m_ready=1
//     -> fifo_rinc=1 for one cycle; next cycle m_valid=1, m_data=0xA5; word_cnt=1.
//  2. FIFO holding 0x01..0x08, m_ready=1
//     -> 8 consecutive m_valid cycles with data 0x01..0x08 in order, no gaps after the first word.
//  3. m_ready=0 with a full FIFO
//     -> exactly 2 pops, then fifo_rinc=0; m_data stays 0x01 until m_ready=1; no word lost or repeated.
//  4. enable 1->0 with count=2, then m_ready=1
//     -> no further fifo_rinc; 2 words delivered; drain_done is a single pulse; busy=0 afterwards.
//  5. fifo_rempty=1 throughout in RUN
//     -> fifo_rinc never 1 and m_valid stays 0; with CNTW=4, 17 pops give word_cnt=1 (wrap).
//  6. rrst=1 mid-stream with count=2
//     -> fifo_rinc=0 in the same cycle; next cycle m_valid=0, word_cnt=0, state IDLE.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the read-side FIFO stream consumer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/rd_skid_buffer.sv
// Two-entry push/pop buffer; entry0 is always the head word presented downstream.
module rd_skid_buffer
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DSIZE-1:0] din_i,
  output logic [DSIZE-1:0] dout_o,
  output logic [1:0]       count_o
);

  logic [DSIZE-1:0] entry0_q, entry0_d;
  logic [DSIZE-1:0] entry1_q, entry1_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    // NOTE: every target gets a default before the case, so no path can infer a latch.
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) entry0_d = din_i;
        else                 entry1_d = din_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'(RD_BUF_DEPTH)) entry0_d = entry1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the count; the new word replaces or follows the head.
        if (count_q == 2'd1) begin
          entry0_d = din_i;
        end else begin
          entry0_d = entry1_q;
          entry1_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      // NOTE: the two data entries are reset because the stream output must read 0 after reset.
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign dout_o  = entry0_q;
  assign count_o = count_q;

endmodule

// File: rtl/fifo_read_stream.sv
// Read-domain FIFO consumer: fetches words into a 2-entry buffer and streams them out
// on valid/ready, with a start/run/drain FSM and a delivered-word counter.
module fifo_read_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             enable,
  input  logic [DSIZE-1:0] fifo_rdata,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             drain_done,
  output logic             busy,
  output logic [CNTW-1:0]  word_cnt
);

  rd_state_e       state_q, state_d;
  logic [CNTW-1:0] word_cnt_q;
  logic            drain_done_q;
  logic [1:0]      buf_count;
  logic            pop;

  // Fetch depends only on registered state and FIFO flags, never on m_ready.
  assign fifo_rinc = (state_q == RUN) & ~fifo_rempty
                   & (buf_count < 2'(RD_BUF_DEPTH)) & ~rrst;
  assign m_valid   = (buf_count != 2'd0);
  assign pop       = m_valid & m_ready;

  rd_skid_buffer #(
    .DSIZE (DSIZE)
  ) u_buf (
    .rclk    (rclk),
    .rrst    (rrst),
    .push_i  (fifo_rinc),
    .pop_i   (pop),
    .din_i   (fifo_rdata),
    .dout_o  (m_data),
    .count_o (buf_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN:   if (buf_count == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= (state_q == DRAIN) && (buf_count == 2'd0);
      if (pop) word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

  assign drain_done = drain_done_q;
  assign busy       = (state_q != IDLE);
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_fifo_read_stream.sv
// Directed bench for fifo_read_stream with a first-word-fall-through FIFO model.
module tb_fifo_read_stream;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       enable;
  logic [7:0] fifo_rdata;
  logic       fifo_rempty;
  logic       fifo_rinc;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       drain_done;
  logic       busy;
  logic [3:0] word_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:31];
  logic [4:0] rd_ptr = 5'd0;
  logic [4:0] wr_ptr = 5'd0;

  assign fifo_rdata  = mem[rd_ptr];
  assign fifo_rempty = (rd_ptr == wr_ptr);

  always #5 rclk = ~rclk;

  always @(posedge rclk) if (fifo_rinc) rd_ptr <= rd_ptr + 5'd1;

  fifo_read_stream #(
    .DSIZE (8),
    .CNTW  (4)
  ) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .enable      (enable),
    .fifo_rdata  (fifo_rdata),
    .fifo_rempty (fifo_rempty),
    .fifo_rinc   (fifo_rinc),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .drain_done  (drain_done),
    .busy        (busy),
    .word_cnt    (word_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #2;
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 5'd1;
  endtask

  // Receives n words starting at value first, checking order, within a cycle budget.
  task automatic collect(input string tag, input logic [7:0] first, input int n, input int budget);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (m_valid) begin
        check(tag, 32'(m_data), 32'(first + 8'(got)));
        got++;
      end
      tick();
    end
    check({tag, "_count"}, 32'(got), 32'(n));
  endtask

  initial begin
    int npops;
    int nrinc;
    int ndone;
    int got;
    int bad;

    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    rrst    = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drain_done", 32'(drain_done), 32'd0);
    check("rst_rinc", 32'(fifo_rinc), 32'd0);

    // 1: single word latency
    rrst = 1'b0;
    push_word(8'hA5);
    enable  = 1'b1;
    m_ready = 1'b1;
    #1;
    check("t1_rinc_idle", 32'(fifo_rinc), 32'd0);
    tick();
    check("t1_rinc", 32'(fifo_rinc), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_valid", 32'(m_valid), 32'd1);
    check("t1_data", 32'(m_data), 32'hA5);
    check("t1_rinc_off", 32'(fifo_rinc), 32'd0);
    tick();
    check("t1_word_cnt", 32'(word_cnt), 32'd1);
    check("t1_valid_off", 32'(m_valid), 32'd0);

    // 2: eight words back to back
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    #1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t2_valid", 32'(m_valid), 32'd1);
      check("t2_data", 32'(m_data), 32'(i));
    end
    tick();
    check("t2_valid_end", 32'(m_valid), 32'd0);
    check("t2_word_cnt", 32'(word_cnt), 32'd9);

    // 3: sink stalled with a full FIFO
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    #1;
    npops = 0;
    bad   = 0;
    for (int i = 0; i < 6; i++) begin
      if (fifo_rinc) npops++;
      tick();
      if (m_valid && m_data !== 8'h01) bad++;
    end
    check("t3_pops", 32'(npops), 32'd2);
    check("t3_hold_stable", 32'(bad), 32'd0);
    check("t3_rinc_off", 32'(fifo_rinc), 32'd0);
    check("t3_head", 32'(m_data), 32'h01);
    m_ready = 1'b1;
    collect("t3_data", 8'h01, 8, 20);
    check("t3_word_cnt", 32'(word_cnt), 32'd1);

    // 4: drain with two buffered words
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
    #1;
    tick();
    tick();
    tick();
    check("t4_full_valid", 32'(m_valid), 32'd1);
    check("t4_full_rinc", 32'(fifo_rinc), 32'd0);
    enable = 1'b0;
    tick();
    check("t4_drain_busy", 32'(busy), 32'd1);
    m_ready = 1'b1;
    #1;
    nrinc = 0;
    ndone = 0;
    got   = 0;
    for (int i = 0; i < 8; i++) begin
      if (fifo_rinc) nrinc++;
      if (drain_done) ndone++;
      if (m_valid) begin
        check("t4_data", 32'(m_data), 32'(8'h11 + 8'(got)));
        got++;
      end
      tick();
    end
    check("t4_no_fetch", 32'(nrinc), 32'd0);
    check("t4_delivered", 32'(got), 32'd2);
    check("t4_done_pulses", 32'(ndone), 32'd1);
    check("t4_busy_off", 32'(busy), 32'd0);
    check("t4_fifo_left", 32'(wr_ptr - rd_ptr), 32'd2);
    check("t4_word_cnt", 32'(word_cnt), 32'd3);
    wr_ptr = rd_ptr;

    // 5: empty FIFO in RUN, then counter wrap
    rrst = 1'b1;
    tick();
    check("t5_rst_word_cnt", 32'(word_cnt), 32'd0);
    rrst    = 1'b0;
    enable  = 1'b1;
    m_ready = 1'b1;
    #1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (fifo_rinc || m_valid) bad++;
      tick();
    end
    check("t5_idle_activity", 32'(bad), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 17; i++) push_word(8'h30 + 8'(i));
    #1;
    collect("t5_data", 8'h30, 17, 40);
    check("t5_word_cnt_wrap", 32'(word_cnt), 32'd1);

    // 6: reset mid-stream
    m_ready = 1'b0;
    push_word(8'hA0);
    push_word(8'hA1);
    push_word(8'hA2);
    #1;
    tick();
    tick();
    check("t6_valid_full", 32'(m_valid), 32'd1);
    rrst = 1'b1;
    #1;
    check("t6_rinc_in_rst", 32'(fifo_rinc), 32'd0);
    tick();
    check("t6_valid", 32'(m_valid), 32'd0);
    check("t6_word_cnt", 32'(word_cnt), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_data", 32'(m_data), 32'd0);
    rrst = 1'b0;
    tick();
    check("t6_rerun_rinc", 32'(fifo_rinc), 32'd1);
    rrst = 1'b1;
    #1;
    check("t6_rinc_forced", 32'(fifo_rinc), 32'd0);
    tick();
    rrst = 1'b0;
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_fifo_untouched", 32'(wr_ptr - rd_ptr), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
